// File: rtl/perf_pkg.sv
// Shared types and defaults for the perf_monitor event-counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int DEF_NUM_CH      = 6;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_CYCLE_LIMIT = 100000;

  // Selector must address NUM_CH channels plus the cycle counter.
  function automatic int sel_w(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single CNT_W event counter with synchronous clear.
// PERF_SAT_EN: saturate at all-ones and raise a sticky sat flag; otherwise wrap, sat tied low.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

`ifdef PERF_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (&cnt) sat <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign sat = 1'b0;
`endif

endmodule

// File: rtl/perf_monitor.sv
// Event/cycle counter bank with run FSM, cycle watchdog and registered read port.
// Optional saturation mode selected by PERF_SAT_EN (see perf_counter).
module perf_monitor
  import perf_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  localparam int SEL_W       = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic              hlt,
  input  logic [NUM_CH-1:0] ev,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [1:0]        state_o,
  output logic              timeout,
  output logic [NUM_CH:0]   sat_flags
);

  // A limit that does not fit in CNT_W can never be reached.
  localparam bit WD_EN = (CYCLE_LIMIT > 0) &&
                         (longint'(CYCLE_LIMIT) <= ((longint'(1) << CNT_W) - 1));
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(longint'(CYCLE_LIMIT) - 1);

  state_t state, state_nxt;

  logic [NUM_CH:0][CNT_W-1:0] cnt;
  logic [NUM_CH:0]            inc;
  logic [NUM_CH:0]            sat;
  logic                       counting;
  logic                       wd_hit;
  logic [CNT_W-1:0]           rd_mux;
  logic                       rd_take;

  assign counting = (state == ST_COUNT);
  assign inc      = {1'b1, ev} & {(NUM_CH+1){counting}};
  assign wd_hit   = WD_EN && counting && (cnt[NUM_CH] == WD_LAST);

  // Index NUM_CH is the cycle counter.
  for (genvar i = 0; i <= NUM_CH; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[i]),
      .cnt   (cnt[i]),
      .sat   (sat[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_COUNT;
        ST_COUNT: begin
          if (hlt)         state_nxt = ST_HALTED;
          else if (wd_hit) state_nxt = ST_TIMEOUT;
        end
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_sel <= SEL_W'(NUM_CH)) rd_mux = cnt[rd_sel];
  end

  assign rd_take = rd_req & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_take;
      rd_data  <= rd_take ? rd_mux : '0;
    end
  end

  assign state_o   = state;
  assign timeout   = (state == ST_TIMEOUT);
  assign sat_flags = sat;

endmodule

// File: tb/tb_perf_monitor.sv
// Randomized + directed bench for perf_monitor; two instances (no watchdog, watchdog=20) share stimulus.
module tb_perf_monitor;

  localparam int NCH = 6;
  localparam int W   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clr = 1'b0, hlt = 1'b0, rd_req = 1'b0;
  logic [5:0] ev = '0;
  logic [2:0] rd_sel = '0;

  logic       rd_valid  [2];
  logic [7:0] rd_data   [2];
  logic [1:0] state_o   [2];
  logic       timeout   [2];
  logic [6:0] sat_flags [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: unbounded true counts, state as plain ints.
  int m_st  [2];
  int m_cnt [2][7];
  bit m_v   [2];
  int m_d   [2];

  always #5 clk = ~clk;

  perf_monitor #(.NUM_CH(NCH), .CNT_W(W), .CYCLE_LIMIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .hlt(hlt), .ev(ev),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .state_o(state_o[0]), .timeout(timeout[0]), .sat_flags(sat_flags[0]));

  perf_monitor #(.NUM_CH(NCH), .CNT_W(W), .CYCLE_LIMIT(20)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .hlt(hlt), .ev(ev),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .state_o(state_o[1]), .timeout(timeout[1]), .sat_flags(sat_flags[1]));

  function automatic int lim(input int k);
    return (k == 0) ? 0 : 20;
  endfunction

  // Visible counter value for a true event count.
  function automatic int view(input int x);
`ifdef PERF_SAT_EN
    return (x > 255) ? 255 : x;
`else
    return x % 256;
`endif
  endfunction

  function automatic int satb(input int x);
`ifdef PERF_SAT_EN
    return (x > 255) ? 1 : 0;
`else
    return (x < 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0;
      m_v[k]  = 1'b0;
      m_d[k]  = 0;
      for (int i = 0; i < 7; i++) m_cnt[k][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit trip;
      m_v[k] = rd_req && !clr;
      m_d[k] = (m_v[k] && int'(rd_sel) <= NCH) ? view(m_cnt[k][rd_sel]) : 0;
      if (clr) begin
        m_st[k] = 0;
        for (int i = 0; i < 7; i++) m_cnt[k][i] = 0;
      end else if (m_st[k] == 1) begin
        trip = (lim(k) != 0) && (view(m_cnt[k][6]) == lim(k) - 1) && !hlt;
        for (int i = 0; i < NCH; i++) if (ev[i]) m_cnt[k][i]++;
        m_cnt[k][6]++;
        if (hlt)       m_st[k] = 2;
        else if (trip) m_st[k] = 3;
      end else if (m_st[k] == 0 && start) begin
        m_st[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int es = 0;
      for (int i = 0; i < 7; i++) es |= satb(m_cnt[k][i]) << i;
      chk($sformatf("state%0d", k), int'(state_o[k]), m_st[k]);
      chk($sformatf("timeout%0d", k), int'(timeout[k]), (m_st[k] == 3) ? 1 : 0);
      chk($sformatf("sat%0d", k), int'(sat_flags[k]), es);
      chk($sformatf("rd_valid%0d", k), int'(rd_valid[k]), int'(m_v[k]));
      if (m_v[k]) chk($sformatf("rd_data%0d", k), int'(rd_data[k]), m_d[k]);
    end
  endtask

  // Apply inputs for the next rising edge, advance the model, check at the falling edge.
  task automatic tick(input bit s = 0, input bit c = 0, input bit h = 0,
                      input bit [5:0] e = 0, input bit rq = 0, input bit [2:0] rs = 0);
    start = s; clr = c; hlt = h; ev = e; rd_req = rq; rd_sel = rs;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rd_chk(input string tag, input int k, input bit [2:0] sel, input int exp);
    tick(.rq(1'b1), .rs(sel));
    chk(tag, int'(rd_data[k]), exp);
  endtask

  initial begin
    model_reset();
    #2;
    compare_all();
    chk("reset_rd_data", int'(rd_data[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: 10 event cycles plus the hlt cycle.
    tick(.s(1'b1));
    repeat (10) tick(.e(6'b000011));
    tick(.h(1'b1), .e(6'b000011));
    chk("t1_state", int'(state_o[0]), 2);
    rd_chk("t1_ch0", 0, 3'd0, 11);
    rd_chk("t1_ch1", 0, 3'd1, 11);
    rd_chk("t1_ch2", 0, 3'd2, 0);
    rd_chk("t1_cyc", 0, 3'd6, 11);

    // Watchdog trips after exactly 20 counted cycles.
    tick(.c(1'b1));
    tick(.s(1'b1));
    repeat (19) tick();
    chk("t2_pre", int'(state_o[1]), 1);
    tick();
    chk("t2_state", int'(state_o[1]), 3);
    chk("t2_timeout", int'(timeout[1]), 1);
    repeat (4) tick();
    rd_chk("t2_cyc", 1, 3'd6, 20);

    // Back-to-back reads of the running cycle counter.
    tick(.c(1'b1));
    tick(.s(1'b1));
    repeat (3) tick();
    rd_chk("t3_rd0", 0, 3'd6, 3);
    rd_chk("t3_rd1", 0, 3'd6, 4);
    rd_chk("t3_rd2", 0, 3'd6, 5);

    // 300 events on ch0 into an 8-bit counter.
    tick(.c(1'b1));
    tick(.s(1'b1));
    repeat (300) tick(.e(6'b000001));
`ifdef PERF_SAT_EN
    rd_chk("t4_ch0", 0, 3'd0, 255);
    chk("t4_sat0", int'(sat_flags[0][0]), 1);
`else
    rd_chk("t4_ch0", 0, 3'd0, 44);
    chk("t4_sat0", int'(sat_flags[0]), 0);
`endif

    // clr beats same-cycle events; following events ignored in IDLE.
    tick(.c(1'b1), .e(6'h3f), .rq(1'b1), .rs(3'd0));
    chk("t5_clr_rd", int'(rd_valid[0]), 0);
    tick(.e(6'h3f));
    chk("t5_state", int'(state_o[0]), 0);
    rd_chk("t5_ch0", 0, 3'd0, 0);

    // Asynchronous reset mid-run.
    tick(.s(1'b1));
    repeat (5) tick(.e(6'($urandom)), .rq(1'b1), .rs(3'd6));
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("t6_rd_data", int'(rd_data[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    rd_chk("t6_sel7", 0, 3'd7, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      tick(.s(($urandom_range(0, 7) == 0)), .c(($urandom_range(0, 63) == 0)),
           .h(($urandom_range(0, 63) == 0)), .e(6'($urandom)),
           .rq(1'($urandom)), .rs(3'($urandom_range(0, 7))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
